// File: rtl/alu_pkg.sv
// Op codes, instruction field positions and pipeline types shared by alu_issue_unit and Alu.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_LHW = 4'd2;
  localparam logic [3:0] OP_LLW = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_SLL = 4'd8;
  localparam logic [3:0] OP_SRL = 4'd9;
  localparam logic [3:0] OP_SRA = 4'd10;

  localparam int F_OP_LSB  = 28;
  localparam int F_RD_LSB  = 24;
  localparam int F_RS_LSB  = 20;
  localparam int F_RT_LSB  = 16;
  localparam int F_IMM_LSB = 0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  typedef struct packed {
    logic        vld;
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [31:0] src0;
    logic [31:0] src1;
    logic [4:0]  shamt;
  } e1_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    return op <= OP_SRA;
  endfunction

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/Alu.sv
// Registered ALU: saturating ADD/SUB, half-word loads, logic ops and shifts; flags {ov, zr, neg}.
// One cycle from operands to dst; no flow control, it computes every cycle.
module Alu
  import alu_pkg::*;
(
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic [3:0]  op,
  input  logic [31:0] src0,
  input  logic [31:0] src1,
  input  logic [4:0]  shamt,
  output logic [31:0] dst,
  output logic        ov,
  output logic        zr,
  output logic        neg
);

  logic [31:0] dst_q, dst_d;
  logic        ov_q, ov_d;
  logic        zr_q, zr_d;
  logic        neg_q, neg_d;
  logic [32:0] sum;
  logic [31:0] sat_val;

  // Overflow of ADD/SUB always saturates toward the sign of src0.
  assign sat_val = src0[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;

  always_comb begin
    sum   = '0;
    ov_d  = 1'b0;
    dst_d = '0;
    case (op)
      OP_ADD: begin
        sum   = {src0[31], src0} + {src1[31], src1};
        ov_d  = sum[32] ^ sum[31];
        dst_d = ov_d ? sat_val : sum[31:0];
      end
      OP_SUB: begin
        sum   = {src0[31], src0} - {src1[31], src1};
        ov_d  = sum[32] ^ sum[31];
        dst_d = ov_d ? sat_val : sum[31:0];
      end
      OP_LHW:  dst_d = {src1[15:0], src0[15:0]};
      OP_LLW:  dst_d = {{16{src1[15]}}, src1[15:0]};
      OP_AND:  dst_d = src0 & src1;
      OP_OR:   dst_d = src0 | src1;
      OP_XOR:  dst_d = src0 ^ src1;
      OP_NOT:  dst_d = ~src0;
      OP_SLL:  dst_d = src0 << shamt;
      OP_SRL:  dst_d = src0 >> shamt;
      OP_SRA:  dst_d = $unsigned($signed(src0) >>> shamt);
      default: dst_d = '0;
    endcase
    zr_d  = (dst_d == 32'h0);
    neg_d = dst_d[31];
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      dst_q <= '0;
      ov_q  <= 1'b0;
      zr_q  <= 1'b0;
      neg_q <= 1'b0;
    end else begin
      dst_q <= dst_d;
      ov_q  <= ov_d;
      zr_q  <= zr_d;
      neg_q <= neg_d;
    end
  end

  assign dst = dst_q;
  assign ov  = ov_q;
  assign zr  = zr_q;
  assign neg = neg_q;

endmodule

// File: rtl/alu_regfile.sv
// 16x32 register file: two combinational read ports plus a debug port, one synchronous write port.
// Every entry clears asynchronously; no flow control.
module alu_regfile #(
  parameter int NREGS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_vld,
  input  logic [3:0]  wr_addr,
  input  logic [31:0] wr_dat,
  input  logic [3:0]  rd0_addr,
  output logic [31:0] rd0_dat,
  input  logic [3:0]  rd1_addr,
  output logic [31:0] rd1_dat,
  input  logic [3:0]  dbg_addr,
  output logic [31:0] dbg_dat
);

  logic [31:0] mem_q [NREGS];
  logic [31:0] mem_d [NREGS];

  always_comb begin
    mem_d = mem_q;
    if (wr_vld) mem_d[wr_addr] = wr_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd0_dat = mem_q[rd0_addr];
  assign rd1_dat = mem_q[rd1_addr];
  assign dbg_dat = mem_q[dbg_addr];

endmodule

// File: rtl/alu_issue_unit.sv
// Issue/writeback stage around Alu: decode, operand select with E2 bypass, writeback two edges after accept.
// Ready drops only in HALT (accepted illegal op); data dependencies never stall.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic [31:0] iInstr,
  input  logic        iInstrValid,
  output logic        oInstrReady,
  input  logic        iClearHalt,
  output logic [3:0]  oAluOp,
  output logic [31:0] oAluSrc0,
  output logic [31:0] oAluSrc1,
  output logic [4:0]  oAluShamt,
  input  logic [31:0] iAluDst,
  input  logic        iAluOv,
  input  logic        iAluZr,
  input  logic        iAluNeg,
  output logic        oWbValid,
  output logic [3:0]  oWbRd,
  output logic [31:0] oWbData,
  output logic [2:0]  oFlags,
  output logic        oHalted,
  input  logic [3:0]  iDbgAddr,
  output logic [31:0] oDbgData
);

  state_t      state_q, state_d;
  logic        rdy_q, rdy_d;
  logic        halted_q, halted_d;
  e1_t         e1_q, e1_d;
  logic        e2_vld_q, e2_vld_d;
  logic [3:0]  e2_rd_q, e2_rd_d;
  logic        wb_vld_q, wb_vld_d;
  logic [3:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_dat_q, wb_dat_d;
  logic [2:0]  flags_q, flags_d;

  logic [3:0]  dec_op, dec_rd, dec_rs, dec_rt, src0_idx;
  logic [15:0] dec_imm;
  logic [31:0] rf_rdat0, rf_rdat1, opnd0, opnd1;
  logic        accept;

  assign dec_op   = iInstr[F_OP_LSB +: 4];
  assign dec_rd   = iInstr[F_RD_LSB +: 4];
  assign dec_rs   = iInstr[F_RS_LSB +: 4];
  assign dec_rt   = iInstr[F_RT_LSB +: 4];
  assign dec_imm  = iInstr[F_IMM_LSB +: 16];
  assign accept   = iInstrValid && rdy_q;
  assign src0_idx = (dec_op == OP_LHW) ? dec_rd : dec_rs;

  alu_regfile #(.NREGS(NREGS)) u_rf (
    .clk      (iClk),
    .rst_n    (iRst_n),
    .wr_vld   (e2_vld_q),
    .wr_addr  (e2_rd_q),
    .wr_dat   (iAluDst),
    .rd0_addr (src0_idx),
    .rd0_dat  (rf_rdat0),
    .rd1_addr (dec_rt),
    .rd1_dat  (rf_rdat1),
    .dbg_addr (iDbgAddr),
    .dbg_dat  (oDbgData)
  );

  // The value being written this edge bypasses the register file, so the write is visible same-cycle.
  assign opnd0 = (e2_vld_q && (e2_rd_q == src0_idx)) ? iAluDst : rf_rdat0;
  assign opnd1 = (e2_vld_q && (e2_rd_q == dec_rt))   ? iAluDst : rf_rdat1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (accept && !is_legal_op(dec_op)) state_d = ST_HALT;
      ST_HALT: if (iClearHalt) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
    rdy_d    = (state_d == ST_RUN);
    halted_d = (state_d == ST_HALT);

    // An empty E1 is all-zero, which presents ADD 0,0 to the Alu.
    e1_d = '0;
    if (accept && is_legal_op(dec_op)) begin
      e1_d.vld   = 1'b1;
      e1_d.op    = dec_op;
      e1_d.rd    = dec_rd;
      e1_d.src0  = opnd0;
      e1_d.src1  = ((dec_op == OP_LHW) || (dec_op == OP_LLW)) ? {16'h0, dec_imm} : opnd1;
      e1_d.shamt = is_shift_op(dec_op) ? dec_imm[4:0] : 5'd0;
    end

    e2_vld_d = e1_q.vld;
    e2_rd_d  = e1_q.rd;
    wb_vld_d = e2_vld_q;
    wb_rd_d  = e2_vld_q ? e2_rd_q : 4'd0;
    wb_dat_d = e2_vld_q ? iAluDst : 32'd0;
    flags_d  = e2_vld_q ? {iAluOv, iAluZr, iAluNeg} : flags_q;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q  <= ST_RUN;
      rdy_q    <= 1'b0;
      halted_q <= 1'b0;
      e1_q     <= '0;
      e2_vld_q <= 1'b0;
      e2_rd_q  <= '0;
      wb_vld_q <= 1'b0;
      wb_rd_q  <= '0;
      wb_dat_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= rdy_d;
      halted_q <= halted_d;
      e1_q     <= e1_d;
      e2_vld_q <= e2_vld_d;
      e2_rd_q  <= e2_rd_d;
      wb_vld_q <= wb_vld_d;
      wb_rd_q  <= wb_rd_d;
      wb_dat_q <= wb_dat_d;
      flags_q  <= flags_d;
    end
  end

  assign oInstrReady = rdy_q;
  assign oHalted     = halted_q;
  assign oAluOp      = e1_q.op;
  assign oAluSrc0    = e1_q.src0;
  assign oAluSrc1    = e1_q.src1;
  assign oAluShamt   = e1_q.shamt;
  assign oWbValid    = wb_vld_q;
  assign oWbRd       = wb_rd_q;
  assign oWbData     = wb_dat_q;
  assign oFlags      = flags_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit + Alu: reference model feeds a scoreboard checked on each writeback.
module tb_alu_issue_unit;

  localparam logic [3:0] K_ADD = 4'd0, K_SUB = 4'd1, K_LHW = 4'd2, K_LLW = 4'd3;
  localparam logic [3:0] K_AND = 4'd4, K_OR = 4'd5, K_XOR = 4'd6, K_NOT = 4'd7;
  localparam logic [3:0] K_SLL = 4'd8, K_SRL = 4'd9, K_SRA = 4'd10;
  localparam longint MAX_POS = 64'sd2147483647;
  localparam longint MIN_NEG = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] instr = '0;
  logic        instr_vld = 1'b0;
  logic        instr_rdy;
  logic        clear_halt = 1'b0;
  logic [3:0]  alu_op;
  logic [31:0] alu_src0, alu_src1, alu_dst;
  logic [4:0]  alu_shamt;
  logic        alu_ov, alu_zr, alu_neg;
  logic        wb_vld;
  logic [3:0]  wb_rd;
  logic [31:0] wb_dat;
  logic [2:0]  flags;
  logic        halted;
  logic [3:0]  dbg_addr = '0;
  logic [31:0] dbg_dat;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] mreg [16];

  typedef struct {
    int          cyc;
    logic [3:0]  rd;
    logic [31:0] dat;
    logic [2:0]  flg;
  } exp_t;
  exp_t sb [$];
  exp_t mon_e;

  alu_issue_unit #(.NREGS(16)) dut (
    .iClk        (clk),
    .iRst_n      (rst_n),
    .iInstr      (instr),
    .iInstrValid (instr_vld),
    .oInstrReady (instr_rdy),
    .iClearHalt  (clear_halt),
    .oAluOp      (alu_op),
    .oAluSrc0    (alu_src0),
    .oAluSrc1    (alu_src1),
    .oAluShamt   (alu_shamt),
    .iAluDst     (alu_dst),
    .iAluOv      (alu_ov),
    .iAluZr      (alu_zr),
    .iAluNeg     (alu_neg),
    .oWbValid    (wb_vld),
    .oWbRd       (wb_rd),
    .oWbData     (wb_dat),
    .oFlags      (flags),
    .oHalted     (halted),
    .iDbgAddr    (dbg_addr),
    .oDbgData    (dbg_dat)
  );

  Alu u_alu (
    .iClk   (clk),
    .iRst_n (rst_n),
    .op     (alu_op),
    .src0   (alu_src0),
    .src1   (alu_src1),
    .shamt  (alu_shamt),
    .dst    (alu_dst),
    .ov     (alu_ov),
    .zr     (alu_zr),
    .neg    (alu_neg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns {ov, zr, neg, dst}.
  function automatic logic [34:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    longint sa, sb2, s;
    logic [31:0] d;
    logic ov;
    sa = $signed(a);
    sb2 = $signed(b);
    s = 0;
    d = '0;
    ov = 1'b0;
    case (op)
      K_ADD, K_SUB: begin
        s = (op == K_ADD) ? sa + sb2 : sa - sb2;
        if (s > MAX_POS) begin d = 32'h7FFF_FFFF; ov = 1'b1; end
        else if (s < MIN_NEG) begin d = 32'h8000_0000; ov = 1'b1; end
        else d = s[31:0];
      end
      K_LHW:   d = {b[15:0], a[15:0]};
      K_LLW:   d = {{16{b[15]}}, b[15:0]};
      K_AND:   d = a & b;
      K_OR:    d = a | b;
      K_XOR:   d = a ^ b;
      K_NOT:   d = ~a;
      K_SLL:   d = a << sh;
      K_SRL:   d = a >> sh;
      K_SRA:   d = $unsigned($signed(a) >>> sh);
      default: d = '0;
    endcase
    return {ov, (d == 32'h0), d[31], d};
  endfunction

  // Called just after a falling edge; the instruction is accepted at the next rising edge.
  task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                       input logic [3:0] rt, input logic [15:0] imm);
    logic [31:0] a, b;
    logic [4:0]  sh;
    logic [34:0] r;
    exp_t        e;
    chk("ready_at_issue", {31'h0, instr_rdy}, 32'h1);
    a  = (op == K_LHW) ? mreg[rd] : mreg[rs];
    b  = ((op == K_LHW) || (op == K_LLW)) ? {16'h0, imm} : mreg[rt];
    sh = (op inside {K_SLL, K_SRL, K_SRA}) ? imm[4:0] : 5'd0;
    r  = ref_alu(op, a, b, sh);
    e.cyc = cyc + 3;
    e.rd  = rd;
    e.dat = r[31:0];
    e.flg = r[34:32];
    sb.push_back(e);
    mreg[rd] = r[31:0];
    instr = {op, rd, rs, rt, imm};
    instr_vld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic dbg_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, dbg_dat, exp);
  endtask

  // Writeback monitor: every pulse must match the oldest expectation in value and cycle.
  always @(negedge clk) begin
    if (wb_vld) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected", {31'h0, wb_vld}, 32'h0);
      end else begin
        mon_e = sb.pop_front();
        chk("wb_cycle", cyc, mon_e.cyc);
        chk("wb_rd", {28'h0, wb_rd}, {28'h0, mon_e.rd});
        chk("wb_data", wb_dat, mon_e.dat);
        chk("wb_flags", {29'h0, flags}, {29'h0, mon_e.flg});
      end
    end else if ((sb.size() != 0) && (sb[0].cyc < cyc)) begin
      chk("wb_missing", {31'h0, wb_vld}, 32'h1);
      void'(sb.pop_front());
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) mreg[i] = '0;

    // Reset state
    rst_n = 1'b0;
    idle(2);
    chk("rst_ready", {31'h0, instr_rdy}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_wb_vld", {31'h0, wb_vld}, 32'h0);
    chk("rst_flags", {29'h0, flags}, 32'h0);
    chk("rst_alu_op", {28'h0, alu_op}, 32'h0);
    chk("rst_alu_src0", alu_src0, 32'h0);
    chk("rst_alu_src1", alu_src1, 32'h0);
    chk("rst_wb_data", wb_dat, 32'h0);
    dbg_chk("rst_dbg_r7", 4'd7, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("ready_before_edge", {31'h0, instr_rdy}, 32'h0);
    idle(1);
    chk("ready_after_release", {31'h0, instr_rdy}, 32'h1);

    // LLW sign-extends; LHW two slots later reads R2 through the E2 bypass
    issue(K_ADD, 4'd1, 4'd0, 4'd0, 16'h0000);
    issue(K_LLW, 4'd2, 4'd0, 4'd0, 16'h8001);
    issue(K_ADD, 4'd5, 4'd1, 4'd1, 16'h0000);
    issue(K_LHW, 4'd2, 4'd0, 4'd0, 16'h1234);
    chk("llw_flags", {29'h0, flags}, 32'h1);
    dbg_chk("llw_r2", 4'd2, 32'hFFFF_8001);
    idle(4);
    dbg_chk("lhw_r2", 4'd2, 32'h1234_8001);

    // Saturating chain issued every cycle
    issue(K_LLW, 4'd2, 4'd0, 4'd0, 16'h0000);
    issue(K_ADD, 4'd6, 4'd0, 4'd0, 16'h0000);
    issue(K_LHW, 4'd2, 4'd0, 4'd0, 16'h4000);
    issue(K_ADD, 4'd7, 4'd0, 4'd0, 16'h0000);
    for (int i = 0; i < 4; i++) issue(K_ADD, 4'd3, 4'd2, 4'd2, 16'h0000);
    idle(4);
    dbg_chk("chain_r3", 4'd3, 32'h7FFF_FFFF);
    chk("chain_flags", {29'h0, flags}, 32'h4);

    // Shifts and logic ops
    issue(K_LLW, 4'd2, 4'd0, 4'd0, 16'h0000);
    issue(K_ADD, 4'd6, 4'd0, 4'd0, 16'h0000);
    issue(K_LHW, 4'd2, 4'd0, 4'd0, 16'h8000);
    issue(K_ADD, 4'd7, 4'd0, 4'd0, 16'h0000);
    issue(K_SRA, 4'd8, 4'd2, 4'd0, 16'h0004);
    issue(K_LLW, 4'd4, 4'd0, 4'd0, 16'h0001);
    issue(K_SRL, 4'd10, 4'd2, 4'd0, 16'h0004);
    issue(K_SLL, 4'd9, 4'd4, 4'd0, 16'h001F);
    issue(K_SUB, 4'd11, 4'd1, 4'd2, 16'h0000);
    issue(K_XOR, 4'd12, 4'd2, 4'd8, 16'h0000);
    issue(K_NOT, 4'd13, 4'd1, 4'd0, 16'h0000);
    issue(K_OR, 4'd5, 4'd9, 4'd4, 16'h0000);
    issue(K_AND, 4'd6, 4'd2, 4'd8, 16'h0000);
    idle(4);
    dbg_chk("sra_r8", 4'd8, 32'hF800_0000);
    dbg_chk("sll_r9", 4'd9, 32'h8000_0000);

    // Illegal op halts; earlier instruction still retires
    issue(K_ADD, 4'd14, 4'd4, 4'd4, 16'h0000);
    instr = 32'hC000_0000;
    instr_vld = 1'b1;
    idle(1);
    chk("halt_halted", {31'h0, halted}, 32'h1);
    chk("halt_ready", {31'h0, instr_rdy}, 32'h0);
    instr = {K_ADD, 4'd15, 4'd4, 4'd4, 16'h0000};
    idle(3);
    chk("halt_ready_held", {31'h0, instr_rdy}, 32'h0);
    instr_vld = 1'b0;
    dbg_chk("halt_r15_untouched", 4'd15, 32'h0);
    dbg_chk("halt_r14_retired", 4'd14, 32'h2);
    @(negedge clk);
    clear_halt = 1'b1;
    idle(1);
    clear_halt = 1'b0;
    chk("clear_ready", {31'h0, instr_rdy}, 32'h1);
    chk("clear_halted", {31'h0, halted}, 32'h0);
    clear_halt = 1'b1;
    idle(1);
    clear_halt = 1'b0;
    chk("clear_in_run_ready", {31'h0, instr_rdy}, 32'h1);
    instr = 32'hF123_4567;
    instr_vld = 1'b1;
    clear_halt = 1'b1;
    idle(1);
    instr_vld = 1'b0;
    clear_halt = 1'b0;
    chk("illegal_with_clear_halted", {31'h0, halted}, 32'h1);
    chk("illegal_with_clear_ready", {31'h0, instr_rdy}, 32'h0);
    clear_halt = 1'b1;
    idle(1);
    clear_halt = 1'b0;
    chk("reclear_ready", {31'h0, instr_rdy}, 32'h1);
    idle(3);

    // Reset with two instructions in flight
    issue(K_LLW, 4'd1, 4'd0, 4'd0, 16'h00AA);
    issue(K_LLW, 4'd2, 4'd0, 4'd0, 16'h00BB);
    rst_n = 1'b0;
    sb.delete();
    for (int i = 0; i < 16; i++) mreg[i] = '0;
    idle(2);
    chk("midrst_wb_vld", {31'h0, wb_vld}, 32'h0);
    chk("midrst_ready", {31'h0, instr_rdy}, 32'h0);
    rst_n = 1'b1;
    idle(3);
    for (int i = 0; i < 16; i++) dbg_chk("midrst_dbg", i[3:0], 32'h0);
    @(negedge clk);

    // Recovery after reset
    issue(K_LLW, 4'd1, 4'd0, 4'd0, 16'h0005);
    idle(4);
    dbg_chk("recover_r1", 4'd1, 32'h5);
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
